// File: rtl/mips_mem_loader_if.sv
// Host loader and core memory bus bundle for mips_mem_loader.
// master drives host/core requests, slave is the memory side.
interface mips_mem_loader_if #(
  parameter int WIDTH    = 8,
  parameter int ADDRBITS = 6
);
  logic                load_start;
  logic                byte_valid;
  logic [7:0]          byte_data;
  logic                core_reset;
  logic [WIDTH-1:0]    core_adr;
  logic                core_memread;
  logic                core_memwrite;
  logic [WIDTH-1:0]    core_writedata;
  logic [WIDTH-1:0]    core_memdata;
  logic                running;
  logic [ADDRBITS-1:0] dbg_adr;
  logic [7:0]          dbg_data;

  modport master (
    output load_start, byte_valid, byte_data,
    output core_adr, core_memread, core_memwrite,
    output core_writedata, dbg_adr,
    input  core_reset, core_memdata, running, dbg_data
  );

  modport slave (
    input  load_start, byte_valid, byte_data,
    input  core_adr, core_memread, core_memwrite,
    input  core_writedata, dbg_adr,
    output core_reset, core_memdata, running, dbg_data
  );
endinterface

// File: rtl/mips_mem_loader.sv
// Unified I/D RAM for the 8-bit multicycle MIPS core with a host
// byte-stream program loader that holds the core in reset while loading.
module mips_mem_loader #(
  parameter int WIDTH    = 8,
  parameter int ADDRBITS = 6
) (
  input logic           clk,
  input logic           reset,
  mips_mem_loader_if.slave bus
);
  localparam int DEPTH = 2 ** ADDRBITS;

  localparam logic [1:0] HOLD = 2'd0;
  localparam logic [1:0] LEN  = 2'd1;
  localparam logic [1:0] DATA = 2'd2;
  localparam logic [1:0] RUN  = 2'd3;

  logic [1:0]          state;
  logic [ADDRBITS-1:0] len;
  logic [ADDRBITS-1:0] cnt;
  logic [ADDRBITS-1:0] len_m1;
  logic [ADDRBITS-1:0] cadr;
  logic [7:0]          mem [DEPTH];

  logic host_we;
  logic core_we;
  logic last;

  assign cadr   = bus.core_adr[ADDRBITS-1:0];
  assign len_m1 = len - 1'b1;
  // len==0 gives len_m1 == all ones, i.e. a full-depth load
  assign last   = (cnt == len_m1);

  assign host_we = !reset && (state == DATA)
                && bus.byte_valid && !bus.load_start;
  assign core_we = !reset && (state == RUN)
                && bus.core_memwrite;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= HOLD;
      len   <= '0;
      cnt   <= '0;
    end else if (bus.load_start) begin
      state <= LEN;
    end else begin
      unique case (state)
        LEN: begin
          if (bus.byte_valid) begin
            len   <= bus.byte_data[ADDRBITS-1:0];
            cnt   <= '0;
            state <= DATA;
          end
        end
        DATA: begin
          if (bus.byte_valid) begin
            cnt <= cnt + 1'b1;
            if (last) state <= RUN;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (host_we)
      mem[cnt] <= bus.byte_data;
    else if (core_we)
      mem[cadr] <= bus.core_writedata[7:0];
  end

  assign bus.running    = (state == RUN);
  assign bus.core_reset = (state != RUN);
  assign bus.core_memdata = bus.running
                          ? WIDTH'(mem[cadr]) : '0;
  assign bus.dbg_data   = mem[bus.dbg_adr];

  // memread is a pure hint; high address bits alias
  logic unused_bits;
  assign unused_bits = ^{bus.core_memread,
                         bus.core_adr[WIDTH-1:ADDRBITS],
                         bus.core_writedata};
endmodule

// File: tb/tb_mips_mem_loader.sv
// Randomized bench for mips_mem_loader against a transaction-level
// model of the loader (remaining-byte count plus shadow RAM).
module tb_mips_mem_loader;
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  mips_mem_loader_if #(.WIDTH(8), .ADDRBITS(6)) bus ();

  mips_mem_loader #(.WIDTH(8), .ADDRBITS(6)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int tests = 0;
  int fails = 0;

  logic [7:0] m_mem [64];
  bit         m_vld [64];
  bit         m_run  = 0;
  bit         m_want = 0;
  int         m_left = 0;
  int         m_ptr  = 0;
  bit         chk_en = 0;
  bit         rand_core = 0;

  task automatic chk(string n, logic [7:0] act, logic [7:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", n, act, exp, $time);
    end
  endtask

  // model advances on each edge from the inputs held during the cycle
  task automatic tick();
    int a;
    bit was_run;
    @(posedge clk);
    was_run = m_run;
    if (!reset && was_run && bus.core_memwrite) begin
      a = int'(bus.core_adr) % 64;
      m_mem[a] = bus.core_writedata;
      m_vld[a] = 1;
    end
    if (reset) begin
      m_run = 0; m_want = 0; m_left = 0;
    end else if (bus.load_start) begin
      m_run = 0; m_want = 1; m_left = 0;
    end else if (bus.byte_valid) begin
      if (m_want) begin
        m_left = int'(bus.byte_data) % 64;
        if (m_left == 0) m_left = 64;
        m_ptr  = 0;
        m_want = 0;
      end else if (m_left > 0) begin
        m_mem[m_ptr] = bus.byte_data;
        m_vld[m_ptr] = 1;
        m_ptr  = (m_ptr + 1) % 64;
        m_left--;
        if (m_left == 0) m_run = 1;
      end
    end
    #1;
    bus.dbg_adr = 6'($urandom);
    if (rand_core) begin
      bus.core_adr       = 8'($urandom);
      bus.core_writedata = 8'($urandom);
      bus.core_memwrite  = ($urandom_range(0, 3) == 0);
      bus.core_memread   = $urandom_range(0, 1) == 1;
    end
  endtask

  always @(negedge clk) begin
    int a;
    if (chk_en) begin
      chk("core_reset", {7'b0, bus.core_reset}, {7'b0, !m_run});
      chk("running", {7'b0, bus.running}, {7'b0, m_run});
      a = int'(bus.core_adr) % 64;
      if (!m_run)
        chk("memdata_gate", bus.core_memdata, 8'h00);
      else if (m_vld[a])
        chk("memdata", bus.core_memdata, m_mem[a]);
      if (m_vld[bus.dbg_adr])
        chk("dbg", bus.dbg_data, m_mem[bus.dbg_adr]);
    end
  end

  task automatic idle(int n);
    bus.load_start = 0;
    bus.byte_valid = 0;
    repeat (n) tick();
  endtask

  task automatic start();
    bus.load_start = 1;
    bus.byte_valid = 0;
    tick();
    bus.load_start = 0;
  endtask

  task automatic send(logic [7:0] b);
    bus.load_start = 0;
    bus.byte_valid = 1;
    bus.byte_data  = b;
    tick();
    bus.byte_valid = 0;
  endtask

  task automatic peek(logic [5:0] a, logic [7:0] exp, string n);
    bus.dbg_adr = a;
    #1;
    chk(n, bus.dbg_data, exp);
  endtask

  task automatic core_idle();
    bus.core_adr       = 8'h00;
    bus.core_memwrite  = 0;
    bus.core_memread   = 0;
    bus.core_writedata = 8'h00;
  endtask

  initial begin
    logic [7:0] x;
    logic [7:0] y;
    logic [7:0] bytes4 [4];
    int n;
    for (int i = 0; i < 64; i++) m_vld[i] = 0;
    bus.load_start = 0;
    bus.byte_valid = 0;
    bus.byte_data  = 8'h00;
    bus.dbg_adr    = 6'h00;
    core_idle();

    reset = 1;
    tick(); tick();
    chk_en = 1;
    chk("rst_core_reset", {7'b0, bus.core_reset}, 8'h01);
    chk("rst_running", {7'b0, bus.running}, 8'h00);
    reset = 0;

    // byte strobes in HOLD must not start anything
    send(8'h04); send(8'h55); idle(1);
    chk("hold_running", {7'b0, bus.running}, 8'h00);

    start();
    send(8'h04); send(8'hAA); send(8'hBB); send(8'hCC);
    chk("pre_last_running", {7'b0, bus.running}, 8'h00);
    send(8'hDD);
    chk("post_last_running", {7'b0, bus.running}, 8'h01);
    chk("post_last_core_reset", {7'b0, bus.core_reset}, 8'h00);
    peek(6'd0, 8'hAA, "basic_0");
    peek(6'd1, 8'hBB, "basic_1");
    peek(6'd2, 8'hCC, "basic_2");
    peek(6'd3, 8'hDD, "basic_3");

    // gapped bytes
    bytes4 = '{8'h11, 8'h22, 8'h33, 8'h44};
    start(); idle(2);
    send(8'hC4); idle(3);
    for (int i = 0; i < 4; i++) begin
      send(bytes4[i]);
      if (i < 3) begin
        idle(3);
        chk("gap_running", {7'b0, bus.running}, 8'h00);
      end
    end
    chk("gap_done", {7'b0, bus.running}, 8'h01);
    peek(6'd2, 8'h33, "gap_2");

    // full depth via length 0
    start();
    send(8'h00);
    for (int i = 0; i < 64; i++) begin
      chk("full_not_yet", {7'b0, bus.running}, 8'h00);
      send(8'(i));
    end
    chk("full_run", {7'b0, bus.running}, 8'h01);
    for (int i = 0; i < 64; i++)
      peek(6'(i), 8'(i), "full_mem");

    // aliased core write
    bus.core_adr = 8'h43;
    bus.core_writedata = 8'h5A;
    bus.core_memwrite = 1;
    tick();
    core_idle();
    bus.core_adr = 8'h03;
    #1;
    chk("alias_memdata", bus.core_memdata, 8'h5A);
    peek(6'd3, 8'h5A, "alias_dbg");

    // restart from RUN with a colliding byte
    bus.load_start = 1;
    bus.byte_valid = 1;
    bus.byte_data  = 8'h10;
    tick();
    bus.load_start = 0;
    bus.byte_valid = 0;
    chk("restart_core_reset", {7'b0, bus.core_reset}, 8'h01);
    send(8'h02); send(8'h77); send(8'h88);
    chk("restart_run", {7'b0, bus.running}, 8'h01);
    peek(6'd0, 8'h77, "restart_0");
    peek(6'd1, 8'h88, "restart_1");

    // end-to-end: core does lb/lb/add/sb on 5 and 7
    start();
    send(8'h02); send(8'h05); send(8'h07);
    bus.core_memread = 1;
    bus.core_adr = 8'h00; #1; x = bus.core_memdata;
    tick();
    bus.core_adr = 8'h41; #1; y = bus.core_memdata;
    tick();
    bus.core_memread  = 0;
    bus.core_adr      = 8'h82;
    bus.core_writedata = x + y;
    bus.core_memwrite = 1;
    tick();
    core_idle();
    peek(6'd2, 8'h0C, "e2e_store");

    // writes blocked and data gated while not running
    rand_core = 1;
    reset = 1; tick(); reset = 0;
    idle(3);
    start();
    send(8'h08);
    for (int i = 0; i < 3; i++) send(8'($urandom));
    reset = 1; tick(); reset = 0;
    chk("midreset_running", {7'b0, bus.running}, 8'h00);
    idle(4);

    // random loads with random gaps and core traffic
    for (int k = 0; k < 25; k++) begin
      start();
      if ($urandom_range(0, 1) == 1) idle($urandom_range(0, 2));
      n = $urandom_range(0, 63);
      send(8'($urandom_range(0, 3) * 64 + n));
      if (n == 0) n = 64;
      for (int i = 0; i < n; i++) begin
        if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
        if ($urandom_range(0, 40) == 0) break;
        send(8'($urandom));
      end
      idle($urandom_range(1, 20));
      if ($urandom_range(0, 5) == 0) begin
        reset = 1; tick(); reset = 0;
      end
    end
    rand_core = 0;
    core_idle();
    idle(2);
    chk_en = 0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
